trb_in_dispatch: RTL

//  Input-side frame scheduler for the NLB AFU turbo decoder array.

---
 rtl/trb_in_dispatch.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/trb_in_dispatch.sv
// Input-side frame scheduler for the turbo decoder bank: routes whole fixed-length frames
// round-robin to decoders with free credit and tracks frames in flight per decoder.
//
// state | meaning
// IDLE  | waiting for a sop beat; pick a decoder, drop stray non-sop beats
// XFER  | zero-latency passthrough of FRAME_LEN beats to the selected decoder
module trb_in_dispatch #(
  parameter int NUM_TURBO  = 4,
  parameter int FRAME_LEN  = 128,
  parameter int MAX_CREDIT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           st_data_in,
  input  logic                 st_valid_in,
  input  logic                 st_sop_in,
  input  logic                 st_eop_in,
  output logic                 st_ready_out,
  output logic [7:0]           dec_data_out,
  output logic [NUM_TURBO-1:0] dec_valid_out,
  output logic                 dec_sop_out,
  output logic                 dec_eop_out,
  input  logic [NUM_TURBO-1:0] dec_ready_in,
  input  logic [NUM_TURBO-1:0] dec_done_in,
  output logic [3:0]           sel_idx,
  output logic                 err_len,
  output logic                 err_sop,
  output logic                 err_credit
);

  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);
  localparam logic [3:0]    MAX_CR    = 4'(MAX_CREDIT);
  localparam logic [3:0]    LAST_IDX  = 4'(NUM_TURBO - 1);
  localparam logic [4:0]    NUM_T5    = 5'(NUM_TURBO);

  typedef enum logic {IDLE, XFER} state_t;

  state_t         state, state_nxt;
  logic [3:0]     rr_ptr;
  logic [3:0]     sel_q;
  logic [BW-1:0]  beat_cnt;
  logic [3:0]     credit [NUM_TURBO];

  logic [15:0]          elig16;
  logic [15:0]          ready16;
  logic                 found;
  logic [3:0]           winner;
  logic [4:0]           idx;
  logic                 start;
  logic                 accept;
  logic                 last_beat;
  logic                 frame_done;
  logic [NUM_TURBO-1:0] inc_vec;
  logic [NUM_TURBO-1:0] zero_vec;
  logic                 credit_err;

  // Index vectors are padded to 16 entries so a 4-bit selector addresses them cleanly.
  always_comb begin
    elig16   = '0;
    zero_vec = '0;
    for (int i = 0; i < NUM_TURBO; i++) begin
      elig16[i]   = (credit[i] < MAX_CR);
      zero_vec[i] = (credit[i] == 4'd0);
    end
  end

  assign ready16 = 16'(dec_ready_in);

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NUM_TURBO; k++) begin
      idx = {1'b0, rr_ptr} + 5'(k);
      if (idx >= NUM_T5) idx = idx - NUM_T5;
      if (!found && elig16[idx[3:0]]) begin
        found  = 1'b1;
        winner = idx[3:0];
      end
    end
  end

  assign start      = (state == IDLE) && st_valid_in && st_sop_in && found;
  assign accept     = (state == XFER) && st_valid_in && ready16[sel_q];
  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign frame_done = accept && last_beat;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = XFER;
      XFER: if (frame_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    st_ready_out  = 1'b0;
    dec_valid_out = '0;
    dec_sop_out   = 1'b0;
    dec_eop_out   = 1'b0;
    case (state)
      IDLE: st_ready_out = st_valid_in && !st_sop_in;
      XFER: begin
        st_ready_out = ready16[sel_q];
        for (int i = 0; i < NUM_TURBO; i++)
          dec_valid_out[i] = st_valid_in && (sel_q == 4'(i));
        dec_sop_out = (beat_cnt == '0);
        dec_eop_out = last_beat;
      end
      default: st_ready_out = 1'b0;
    endcase
  end

  assign dec_data_out = st_data_in;
  assign sel_idx      = sel_q;

  // Frame length comes from beat_cnt alone; input sop/eop only feed the error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      err_len  <= 1'b0;
      err_sop  <= 1'b0;
    end else begin
      err_len <= accept && ((st_eop_in != last_beat) || (st_sop_in && (beat_cnt != '0)));
      err_sop <= (state == IDLE) && st_valid_in && !st_sop_in;
      if (start) begin
        sel_q    <= winner;
        beat_cnt <= '0;
      end
      if (accept) begin
        if (last_beat) begin
          beat_cnt <= '0;
          rr_ptr   <= (sel_q == LAST_IDX) ? 4'd0 : sel_q + 4'd1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    inc_vec = '0;
    for (int i = 0; i < NUM_TURBO; i++)
      inc_vec[i] = frame_done && (sel_q == 4'(i));
  end

  assign credit_err = |(dec_done_in & ~inc_vec & zero_vec);

  // A completion and a return on the same decoder in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TURBO; i++) credit[i] <= '0;
      err_credit <= 1'b0;
    end else begin
      err_credit <= credit_err;
      for (int i = 0; i < NUM_TURBO; i++) begin
        if (inc_vec[i] && !dec_done_in[i])
          credit[i] <= credit[i] + 4'd1;
        else if (!inc_vec[i] && dec_done_in[i] && !zero_vec[i])
          credit[i] <= credit[i] - 4'd1;
      end
    end
  end

endmodule
